// File: rtl/yuv_rgb_pkg.sv
// Shared fixed-point constants and stage payload types for the YUV<->RGB converters.
// Coefficients are Q14; the accumulator width is chosen so no intermediate sum can overflow.
package yuv_rgb_pkg;

    localparam int FRAC_BITS = 14;
    localparam int ROUND     = 8192;
    localparam int ACC_W     = 30;
    localparam int COEF_W    = 18;
    localparam int PROD_W    = 27;
    localparam int CHROMA_W  = 9;

    localparam logic signed [COEF_W-1:0] C_RV =  18'sd18675;
    localparam logic signed [COEF_W-1:0] C_GU = -18'sd6466;
    localparam logic signed [COEF_W-1:0] C_GV = -18'sd9513;
    localparam logic signed [COEF_W-1:0] C_BU =  18'sd33294;

    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    typedef struct packed {
        logic [7:0] y;
        prod_t      rv;
        prod_t      gu;
        prod_t      gv;
        prod_t      bu;
    } s1_t;

    typedef struct packed {
        acc_t r;
        acc_t g;
        acc_t b;
    } s2_t;

    function automatic prod_t mul_coef(input logic signed [CHROMA_W-1:0] a,
                                       input logic signed [COEF_W-1:0]   c);
        return prod_t'(a) * prod_t'(c);
    endfunction

    // Round-to-nearest via floor shift of (sum + half), then add luma.
    function automatic acc_t round_add_y(input acc_t sum, input logic [7:0] y);
        acc_t y_ext;
        y_ext = acc_t'({1'b0, y});
        return y_ext + ((sum + acc_t'(ROUND)) >>> FRAC_BITS);
    endfunction

endpackage

// File: rtl/yuv_clamp_u8.sv
// Saturates a signed accumulator value to the unsigned 0..255 pixel range.
module yuv_clamp_u8
    import yuv_rgb_pkg::*;
(
    input  acc_t       din,
    output logic [7:0] dout
);

    // NOTE: default assigned first so every path drives dout and no latch is inferred.
    always_comb begin
        dout = din[7:0];
        if (din < 0)
            dout = 8'd0;
        else if (din > acc_t'(255))
            dout = 8'd255;
    end

endmodule

// File: rtl/yuv_to_rgb_pipe.sv
// Three-stage YUV -> RGB888 converter with valid/ready handshake and whole-pipe stall.
// S1 multiplies, S2 sums/rounds/adds luma, S3 clamps into the output registers.
module yuv_to_rgb_pipe
    import yuv_rgb_pkg::*;
#(
    parameter int USER_W = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7:0]                 y,
    input  logic signed [CHROMA_W-1:0] u,
    input  logic signed [CHROMA_W-1:0] v,
    input  logic [USER_W-1:0]          in_user,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 r,
    output logic [7:0]                 g,
    output logic [7:0]                 b,
    output logic [USER_W-1:0]          out_user
);

    logic              adv;
    logic              s1_valid, s2_valid;
    s1_t               s1, s1_d;
    s2_t               s2, s2_d;
    logic [USER_W-1:0] s1_user, s2_user;
    logic [7:0]        r_d, g_d, b_d;

    // The whole pipe moves together, so the output register being free is the only gate.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign s1_d = '{y:  y,
                    rv: mul_coef(v, C_RV),
                    gu: mul_coef(u, C_GU),
                    gv: mul_coef(v, C_GV),
                    bu: mul_coef(u, C_BU)};

    assign s2_d = '{r: round_add_y(acc_t'(s1.rv), s1.y),
                    g: round_add_y(acc_t'(s1.gu) + acc_t'(s1.gv), s1.y),
                    b: round_add_y(acc_t'(s1.bu), s1.y)};

    yuv_clamp_u8 u_clamp_r (.din(s2.r), .dout(r_d));
    yuv_clamp_u8 u_clamp_g (.din(s2.g), .dout(g_d));
    yuv_clamp_u8 u_clamp_b (.din(s2.b), .dout(b_d));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            r         <= '0;
            g         <= '0;
            b         <= '0;
            out_user  <= '0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (s2_valid) begin
                r        <= r_d;
                g        <= g_d;
                b        <= b_d;
                out_user <= s2_user;
            end
        end
    end

    // NOTE: inner datapath registers carry no reset; their contents are ignored until the
    // matching valid bit is set, so resetting them would only add fan-out on rst_n.
    always_ff @(posedge clk) begin
        if (adv && in_valid) begin
            s1      <= s1_d;
            s1_user <= in_user;
        end
        if (adv && s1_valid) begin
            s2      <= s2_d;
            s2_user <= s1_user;
        end
    end

endmodule

// File: tb/tb_yuv_to_rgb_pipe.sv
// Scoreboard bench for yuv_to_rgb_pipe: directed vectors, backpressure, sideband, mid-stream
// reset and randomized traffic against an integer reference of the conversion formulas.
module tb_yuv_to_rgb_pipe;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, in_ready, out_valid, out_ready;
    logic [7:0]        y, r, g, b;
    logic signed [8:0] u, v;
    logic [1:0]        in_user, out_user;

    int errors = 0;
    int checks = 0;
    int sb_q[$];
    int or_mode = 0;
    int cyc = 0;
    logic [3:0] or_pat = 4'b1001;

    always #5 clk = ~clk;

    yuv_to_rgb_pipe #(.USER_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .y(y), .u(u), .v(v), .in_user(in_user),
        .out_valid(out_valid), .out_ready(out_ready),
        .r(r), .g(g), .b(b), .out_user(out_user)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clamp8(input int x);
        if (x < 0) return 0;
        if (x > 255) return 255;
        return x;
    endfunction

    function automatic int pack(input int rr, input int gg, input int bb, input int us);
        return (rr << 18) | (gg << 10) | (bb << 2) | us;
    endfunction

    // Reference: the conversion formulas evaluated with ordinary integer arithmetic.
    function automatic int model(input int yy, input int uu, input int vv, input int us);
        int rr, gg, bb;
        rr = yy + ((18675 * vv + 8192) >>> 14);
        gg = yy + ((-6466 * uu - 9513 * vv + 8192) >>> 14);
        bb = yy + ((33294 * uu + 8192) >>> 14);
        return pack(clamp8(rr), clamp8(gg), clamp8(bb), us);
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one pixel and pushes the given expectation when it is accepted.
    task automatic send_exp(input logic [7:0] yy, input logic signed [8:0] uu,
                            input logic signed [8:0] vv, input logic [1:0] us, input int exp);
        int guard;
        y = yy; u = uu; v = vv; in_user = us; in_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", int'(in_ready), 1);
        end else begin
            sb_q.push_back(exp);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] yy, input logic signed [8:0] uu,
                        input logic signed [8:0] vv, input logic [1:0] us);
        send_exp(yy, uu, vv, us, model(int'(yy), int'(uu), int'(vv), int'(us)));
    endtask

    task automatic check_latency(input string name);
        int lat;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check(name, lat, 3);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((sb_q.size() != 0 || out_valid) && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain_queue_empty", sb_q.size(), 0);
    endtask

    // Downstream ready generator.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (or_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = or_pat[cyc % 4];
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: handshake rule, hold stability and in-order scoreboard comparison.
    initial begin
        logic hold;
        int   hold_val;
        hold = 1'b0;
        hold_val = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                check("in_ready_rule", int'(in_ready), int'(!out_valid || out_ready));
                if (hold)
                    check("held_output", int'({out_valid, r, g, b, out_user}), hold_val);
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pixel: got 0x%0h with no pixel outstanding",
                                 pack(r, g, b, out_user));
                    end else begin
                        check("pixel", pack(r, g, b, out_user), sb_q.pop_front());
                    end
                end
                hold = out_valid && !out_ready;
                hold_val = int'({out_valid, r, g, b, out_user});
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; y = '0; u = '0; v = '0; in_user = '0;
        idle(3);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_rgb_user", int'({r, g, b, out_user}), 0);
        check("reset_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // Directed vectors with literal expectations and latency.
        send_exp(8'd0,   9'sd0,    9'sd0,   2'd0, pack(0, 0, 0, 0));
        check_latency("latency_black");
        send_exp(8'd255, 9'sd0,    9'sd0,   2'd1, pack(255, 255, 255, 1));
        check_latency("latency_white");
        send_exp(8'd76,  -9'sd37,  9'sd157, 2'd2, pack(255, 0, 1, 2));
        check_latency("latency_red");
        send_exp(8'd255, 9'sd0,    9'sd157, 2'd3, pack(255, 164, 255, 3));
        check_latency("latency_clamp_r");
        send_exp(8'd0,   -9'sd256, 9'sd0,   2'd0, pack(0, 101, 0, 0));
        check_latency("latency_clamp_b");
        drain();

        // Ramp under the 1-0-0-1 ready pattern, issued back to back.
        or_mode = 1;
        for (int i = 0; i < 10; i++)
            send(8'(i * 25), 9'(i * 10 - 50), 9'(50 - i * 10), 2'(i % 4));
        drain();

        // One line of 8 with start/end sideband, random bubbles and stalls.
        or_mode = 2;
        for (int i = 0; i < 8; i++) begin
            idle($urandom_range(0, 2));
            send(8'($urandom_range(0, 255)), 9'($urandom_range(0, 511)),
                 9'($urandom_range(0, 511)), (i == 0) ? 2'b01 : ((i == 7) ? 2'b10 : 2'b00));
        end
        drain();

        // Mid-stream reset with three pixels in flight and downstream stalled.
        or_mode = 3;
        idle(2);
        for (int i = 0; i < 3; i++)
            send(8'(40 + i), 9'sd20, -9'sd20, 2'd3);
        rst_n = 1'b0;
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        or_mode = 0;
        @(negedge clk);
        check("midreset_out_valid", int'(out_valid), 0);
        check("midreset_rgb_user", int'({r, g, b, out_user}), 0);
        check("midreset_in_ready", int'(in_ready), 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_stale_pixel", int'(out_valid), 0);
        end
        @(posedge clk);
        #1;
        send(8'd128, 9'sd50, -9'sd60, 2'd1);
        check_latency("latency_after_reset");
        drain();

        // Randomized traffic with random bubbles and random backpressure.
        or_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0)
                idle($urandom_range(1, 3));
            send(8'($urandom_range(0, 255)), 9'($urandom_range(0, 511)),
                 9'($urandom_range(0, 511)), 2'($urandom_range(0, 3)));
        end
        or_mode = 0;
        drain();
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
